pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline. Combines the taken-branch `clear` from the EX-stage branch resolver, jumps, load-use hazards, multi-cycle EX operations and data-memory wait handshakes into one prioritised set of stall, flush and redirect controls. It sits beside the datapath and drives the enables and flushes of the PC and the IF/ID, ID/EX and EX/MEM pipeline registers.

## Interface
- `MULTI_LAT`, default 4: stall cycles a multi-cycle EX op (mul/div) holds EX; legal range 1..15.
- `MEM_TIMEOUT`, default 255: data-memory wait cycles before `mem_timeout` sets; legal range 1..255.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `ID_rs1`, `ID_rs2`, in, 5: source registers of the instruction in ID.
- `ID_rs1_used`, `ID_rs2_used`, in, 1: the source operand is actually read.
- `EX_rd`, in, 5: destination register of the instruction in EX.
- `EX_mem_read`, in, 1: the instruction in EX is a load.
- `EX_branch_clear`, in, 1: branch resolver reports a taken branch in EX.
- `EX_jump`, in, 1: jal/jalr in EX.
- `EX_multi`, in, 1: multi-cycle op in EX.
- `MEM_access`, in, 1: load/store in MEM.
- `dmem_ready`, in, 1: data memory completes the access this cycle.
- `PC_stall`, `IF_ID_stall`, `ID_EX_stall`, `EX_MEM_stall`, out, 1: hold the register.
- `IF_ID_flush`, `ID_EX_flush`, `MEM_WB_bubble`, out, 1: load a NOP into the register.
- `pc_redirect`, out, 1: PC loads the EX branch/jump target.
- `multi_done`, out, 1: single-cycle pulse when the multi-cycle op is released.
- `mem_timeout`, out, 1: sticky error flag, cleared only by `rst`.
- `stall_count`, out, 16: saturating count of cycles with `PC_stall` asserted.

## Operation
- State register `st` has two states, RUN and MULTI. There is a 4-bit counter `mcnt`, an 8-bit wait counter `wcnt` and the `stall_count` register.
- Condition `mw` = `MEM_access & ~dmem_ready`.
- Condition `lu` = `EX_mem_read & (EX_rd != 0) & ((ID_rs1_used & ID_rs1 == EX_rd) | (ID_rs2_used & ID_rs2 == EX_rd))`.
- Priority, highest first:
  1. `mw`: assert all four stalls and `MEM_WB_bubble`. No flush and no redirect. `mcnt` holds and `st` holds.
  2. MULTI, or RUN with `EX_multi`: assert `PC_stall`, `IF_ID_stall` and `ID_EX_stall`, plus `EX_MEM_stall` = 0 with EX/MEM loaded as a bubble via `MEM_WB_bubble` = 0. The EX/MEM bubble is driven by the datapath when `multi_busy`. This applies except on the release cycle.
  3. `EX_branch_clear | EX_jump`: assert `pc_redirect`, `IF_ID_flush` and `ID_EX_flush`. This overrides `lu`.
  4. `lu`: assert `PC_stall` and `IF_ID_stall`, and set `ID_EX_flush` = 1 (one bubble).
- MULTI sequencing:
  - RUN with `EX_multi & ~mw` goes to MULTI and loads `mcnt` = `MULTI_LAT`-1. That cycle stalls.
  - In MULTI with `mcnt` != 0: stall and decrement.
  - In MULTI with `mcnt` = 0: no stall, `multi_done` = 1, go to RUN. `EX_multi` on this cycle is ignored.
  - Net effect: exactly `MULTI_LAT` stall cycles, and EX is occupied for `MULTI_LAT`+1 cycles.
- A branch or jump cannot coexist with `EX_multi`. If both are asserted, the multi path wins and the redirect is deferred until release.
- `wcnt` increments each `mw` cycle, saturates at 255 and clears when `mw` = 0. `mem_timeout` sets when `wcnt` reaches `MEM_TIMEOUT` while `mw` = 1.
- `stall_count` increments on each `PC_stall` cycle and saturates at 0xFFFF.

## Timing
- All control outputs are combinational from `st`, `mcnt` and the current inputs, and are valid before the next edge.
- State, counters and flags update on the rising edge.
- Reset:
  - `st` = RUN; `mcnt`, `wcnt` and `stall_count` = 0; `mem_timeout` = 0.
  - While `rst` = 1, every stall, flush, redirect and pulse output is forced to 0.
  - Reset during MULTI or a memory wait abandons the op. Operation resumes in RUN on the first cycle after `rst` drops.
- Latencies:
  - Redirect takes effect the same cycle `EX_branch_clear` is seen, giving a 2-instruction flush penalty.
  - Load-use costs exactly 1 bubble.
- Simultaneous events:
  - `mw` with a branch: hold everything. The redirect is issued on the first cycle `mw` = 0, because EX is frozen so `EX_branch_clear` persists.
  - `mw` with `lu`: stall only. The bubble is inserted after `mw` ends.
  - `mw` arriving mid-MULTI freezes `mcnt`.

## Structure
- A shared defines package holds the state encoding (RUN = 1'b0, MULTI = 1'b1), the register-address width (5) and the `stall_count` width (16).
- One natural sub-module, `hazard_detect`: the combinational `lu` comparator. Everything else stays in the top-level module.

## Test plan
- **Load-use:** `EX_mem_read`=1, `EX_rd`=5, `ID_rs1`=5 used. Expect exactly 1 cycle of `PC_stall`/`IF_ID_stall` with `ID_EX_flush`. With `EX_rd`=0, expect no stall.
- **Taken branch:** `EX_branch_clear`=1 for one cycle. Expect `pc_redirect`, `IF_ID_flush` and `ID_EX_flush` in the same cycle and no stall. Repeat with `lu` also true: the flush wins and no stall occurs.
- **Multi-cycle op:** `EX_multi` held with `MULTI_LAT`=4. Expect 4 stall cycles, then `multi_done` pulse and release. `stall_count` = 4.
- **Memory wait:** `dmem_ready`=0 for 3 cycles during MULTI and a pending branch. Expect all stalls, `mcnt` frozen, and the redirect only after ready.
- **Timeout and reset:** `mw` for 256 cycles with `MEM_TIMEOUT`=255. Expect `mem_timeout` to set and stay set after `mw` ends. Then `rst` mid-MULTI: expect all outputs 0 and state RUN on the next cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: state encoding,
// register-address width and stall-counter width.
package pipe_hazard_ctrl_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_MULTI = 1'b1
    } state_e;

    localparam int REG_AW = 5;
    localparam int SC_W   = 16;

    function automatic logic [SC_W-1:0] sat_inc_sc(input logic [SC_W-1:0] v);
        return (v == {SC_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the datapath (master) and the stall/flush
// sequencer (slave).
interface pipe_hazard_ctrl_if;
    import pipe_hazard_ctrl_pkg::*;

    logic [REG_AW-1:0] ID_rs1;
    logic [REG_AW-1:0] ID_rs2;
    logic              ID_rs1_used;
    logic              ID_rs2_used;
    logic [REG_AW-1:0] EX_rd;
    logic              EX_mem_read;
    logic              EX_branch_clear;
    logic              EX_jump;
    logic              EX_multi;
    logic              MEM_access;
    logic              dmem_ready;

    logic              PC_stall;
    logic              IF_ID_stall;
    logic              ID_EX_stall;
    logic              EX_MEM_stall;
    logic              IF_ID_flush;
    logic              ID_EX_flush;
    logic              MEM_WB_bubble;
    logic              pc_redirect;
    logic              multi_done;
    logic              mem_timeout;
    logic [SC_W-1:0]   stall_count;

    modport master (
        output ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used, EX_rd, EX_mem_read,
               EX_branch_clear, EX_jump, EX_multi, MEM_access, dmem_ready,
        input  PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, IF_ID_flush,
               ID_EX_flush, MEM_WB_bubble, pc_redirect, multi_done,
               mem_timeout, stall_count
    );

    modport slave (
        input  ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used, EX_rd, EX_mem_read,
               EX_branch_clear, EX_jump, EX_multi, MEM_access, dmem_ready,
        output PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, IF_ID_flush,
               ID_EX_flush, MEM_WB_bubble, pc_redirect, multi_done,
               mem_timeout, stall_count
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: the load in EX writes a register that the instruction
// in ID actually reads. x0 never creates a dependency.
module hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic              i_id_rs1_used,
    input  logic              i_id_rs2_used,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_ex_mem_read,
    output logic              o_lu
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit = i_id_rs1_used && (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit = i_id_rs2_used && (i_id_rs2 == i_ex_rd);
    assign o_lu      = i_ex_mem_read && (i_ex_rd != '0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer: prioritises memory wait, multi-cycle EX,
// branch/jump redirect and load-use into pipeline register controls.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULTI_LAT   = 4,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus
);

    localparam logic [3:0] MCNT_LOAD = 4'(MULTI_LAT - 1);
    localparam logic [7:0] WAIT_LIM  = 8'(MEM_TIMEOUT);

    state_e          r_st;
    logic [3:0]      r_mcnt;
    logic [7:0]      r_wcnt;
    logic [SC_W-1:0] r_stall_count;
    logic            r_mem_timeout;

    state_e          w_next_st;
    logic [3:0]      w_next_mcnt;
    logic            w_mw;
    logic            w_lu;
    logic            w_pc_stall, w_if_id_stall, w_id_ex_stall, w_ex_mem_stall;
    logic            w_if_id_flush, w_id_ex_flush, w_mem_wb_bubble;
    logic            w_pc_redirect, w_multi_done;

    assign w_mw = bus.MEM_access && !bus.dmem_ready;

    hazard_detect u_hazard_detect (
        .i_id_rs1      (bus.ID_rs1),
        .i_id_rs2      (bus.ID_rs2),
        .i_id_rs1_used (bus.ID_rs1_used),
        .i_id_rs2_used (bus.ID_rs2_used),
        .i_ex_rd       (bus.EX_rd),
        .i_ex_mem_read (bus.EX_mem_read),
        .o_lu          (w_lu)
    );

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no path infers a latch.
        w_next_st       = r_st;
        w_next_mcnt     = r_mcnt;
        w_pc_stall      = 1'b0;
        w_if_id_stall   = 1'b0;
        w_id_ex_stall   = 1'b0;
        w_ex_mem_stall  = 1'b0;
        w_if_id_flush   = 1'b0;
        w_id_ex_flush   = 1'b0;
        w_mem_wb_bubble = 1'b0;
        w_pc_redirect   = 1'b0;
        w_multi_done    = 1'b0;

        if (!rst) begin
            if (w_mw) begin
                // Freeze everything, including the multi-cycle countdown.
                w_pc_stall      = 1'b1;
                w_if_id_stall   = 1'b1;
                w_id_ex_stall   = 1'b1;
                w_ex_mem_stall  = 1'b1;
                w_mem_wb_bubble = 1'b1;
            end else if ((r_st == ST_RUN && bus.EX_multi) ||
                         (r_st == ST_MULTI && r_mcnt != 4'd0)) begin
                w_pc_stall    = 1'b1;
                w_if_id_stall = 1'b1;
                w_id_ex_stall = 1'b1;
                if (r_st == ST_RUN) begin
                    w_next_st   = ST_MULTI;
                    w_next_mcnt = MCNT_LOAD;
                end else begin
                    w_next_mcnt = r_mcnt - 4'd1;
                end
            end else begin
                // Release cycle falls through so a deferred redirect issues now.
                if (r_st == ST_MULTI) begin
                    w_multi_done = 1'b1;
                    w_next_st    = ST_RUN;
                end
                if (bus.EX_branch_clear || bus.EX_jump) begin
                    w_pc_redirect = 1'b1;
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                end else if (w_lu) begin
                    w_pc_stall    = 1'b1;
                    w_if_id_stall = 1'b1;
                    w_id_ex_flush = 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_st          <= ST_RUN;
            r_mcnt        <= 4'd0;
            r_wcnt        <= 8'd0;
            r_stall_count <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_st   <= w_next_st;
            r_mcnt <= w_next_mcnt;
            if (w_mw) begin
                if (r_wcnt != 8'hFF) r_wcnt <= r_wcnt + 8'd1;
                if (r_wcnt >= WAIT_LIM) r_mem_timeout <= 1'b1;
            end else begin
                r_wcnt <= 8'd0;
            end
            if (w_pc_stall) r_stall_count <= sat_inc_sc(r_stall_count);
        end
    end

    assign bus.PC_stall      = w_pc_stall;
    assign bus.IF_ID_stall   = w_if_id_stall;
    assign bus.ID_EX_stall   = w_id_ex_stall;
    assign bus.EX_MEM_stall  = w_ex_mem_stall;
    assign bus.IF_ID_flush   = w_if_id_flush;
    assign bus.ID_EX_flush   = w_id_ex_flush;
    assign bus.MEM_WB_bubble = w_mem_wb_bubble;
    assign bus.pc_redirect   = w_pc_redirect;
    assign bus.multi_done    = w_multi_done;
    assign bus.mem_timeout   = r_mem_timeout;
    assign bus.stall_count   = r_stall_count;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with hand-computed control vectors.
// Control vector order: PC, IF_ID, ID_EX, EX_MEM stall, IF_ID/ID_EX flush, bubble, redirect, done.
module tb_pipe_hazard_ctrl;

    localparam logic [8:0] C_NONE  = 9'b000000000;
    localparam logic [8:0] C_LU    = 9'b110001000;
    localparam logic [8:0] C_BR    = 9'b000011010;
    localparam logic [8:0] C_MULTI = 9'b111000000;
    localparam logic [8:0] C_DONE  = 9'b000000001;
    localparam logic [8:0] C_DNBR  = 9'b000011011;
    localparam logic [8:0] C_MW    = 9'b111100100;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    pipe_hazard_ctrl_if hz ();

    pipe_hazard_ctrl #(.MULTI_LAT(4), .MEM_TIMEOUT(255)) dut (
        .clk (clk),
        .rst (rst),
        .bus (hz)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] ctl();
        return {hz.PC_stall, hz.IF_ID_stall, hz.ID_EX_stall, hz.EX_MEM_stall,
                hz.IF_ID_flush, hz.ID_EX_flush, hz.MEM_WB_bubble,
                hz.pc_redirect, hz.multi_done};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        hz.ID_rs1 = '0; hz.ID_rs2 = '0;
        hz.ID_rs1_used = 1'b0; hz.ID_rs2_used = 1'b0;
        hz.EX_rd = '0; hz.EX_mem_read = 1'b0;
        hz.EX_branch_clear = 1'b0; hz.EX_jump = 1'b0; hz.EX_multi = 1'b0;
        hz.MEM_access = 1'b0; hz.dmem_ready = 1'b1;
    endtask

    task automatic set_lu(input logic [4:0] r);
        hz.EX_mem_read = 1'b1; hz.EX_rd = r;
        hz.ID_rs1 = r; hz.ID_rs1_used = 1'b1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        // Inputs that would otherwise stall/redirect must be masked in reset.
        hz.EX_multi = 1'b1; hz.MEM_access = 1'b1; hz.dmem_ready = 1'b0;
        hz.EX_branch_clear = 1'b1;
        tick(); tick(); settle();
        check("rst_ctl", 32'(ctl()), 32'(C_NONE));
        check("rst_sc", 32'(hz.stall_count), 32'd0);
        check("rst_to", 32'(hz.mem_timeout), 32'd0);

        rst = 1'b0; clear_inputs(); settle();
        check("idle_ctl", 32'(ctl()), 32'(C_NONE));

        // Load-use: exactly one bubble.
        set_lu(5'd5); settle();
        check("lu_ctl", 32'(ctl()), 32'(C_LU));
        tick();
        hz.EX_mem_read = 1'b0; settle();
        check("lu_after", 32'(ctl()), 32'(C_NONE));
        check("lu_sc", 32'(hz.stall_count), 32'd1);
        set_lu(5'd5); hz.ID_rs1_used = 1'b0; settle();
        check("lu_unused", 32'(ctl()), 32'(C_NONE));
        set_lu(5'd0); settle();
        check("lu_x0", 32'(ctl()), 32'(C_NONE));
        clear_inputs();
        hz.EX_mem_read = 1'b1; hz.EX_rd = 5'd7; hz.ID_rs2 = 5'd7; hz.ID_rs2_used = 1'b1;
        settle();
        check("lu_rs2", 32'(ctl()), 32'(C_LU));
        clear_inputs();

        // Taken branch / jump, and flush overriding load-use.
        hz.EX_branch_clear = 1'b1; settle();
        check("br_ctl", 32'(ctl()), 32'(C_BR));
        set_lu(5'd5); settle();
        check("br_lu", 32'(ctl()), 32'(C_BR));
        tick();
        clear_inputs(); hz.EX_jump = 1'b1; settle();
        check("jmp_ctl", 32'(ctl()), 32'(C_BR));
        check("br_sc", 32'(hz.stall_count), 32'd1);
        clear_inputs();

        // Multi-cycle op: 4 stall cycles then a done pulse.
        hz.EX_multi = 1'b1; settle();
        check("mul_s0", 32'(ctl()), 32'(C_MULTI));
        tick();
        for (int i = 1; i < 4; i++) begin
            check($sformatf("mul_s%0d", i), 32'(ctl()), 32'(C_MULTI));
            tick();
        end
        check("mul_done", 32'(ctl()), 32'(C_DONE));
        tick();
        hz.EX_multi = 1'b0; settle();
        check("mul_idle", 32'(ctl()), 32'(C_NONE));
        check("mul_sc", 32'(hz.stall_count), 32'd5);

        // Memory wait mid-MULTI with a pending branch: mcnt frozen, redirect at release.
        hz.EX_multi = 1'b1; hz.EX_branch_clear = 1'b1; settle();
        check("mwb_s0", 32'(ctl()), 32'(C_MULTI));
        tick();
        check("mwb_s1", 32'(ctl()), 32'(C_MULTI));
        tick();
        hz.MEM_access = 1'b1; hz.dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("mwb_w%0d", i), 32'(ctl()), 32'(C_MW));
            tick();
        end
        hz.dmem_ready = 1'b1; settle();
        check("mwb_s2", 32'(ctl()), 32'(C_MULTI));
        tick();
        check("mwb_s3", 32'(ctl()), 32'(C_MULTI));
        tick();
        check("mwb_rel", 32'(ctl()), 32'(C_DNBR));
        tick();
        clear_inputs(); settle();
        check("mwb_sc", 32'(hz.stall_count), 32'd12);

        // Wait with load-use: stall only, bubble once ready.
        hz.MEM_access = 1'b1; hz.dmem_ready = 1'b0; set_lu(5'd9); settle();
        check("mwlu_w", 32'(ctl()), 32'(C_MW));
        tick();
        hz.dmem_ready = 1'b1; settle();
        check("mwlu_lu", 32'(ctl()), 32'(C_LU));
        tick();
        clear_inputs(); hz.MEM_access = 1'b1; settle();
        check("mem_ready", 32'(ctl()), 32'(C_NONE));
        check("mwlu_sc", 32'(hz.stall_count), 32'd14);

        // Timeout: 256 wait cycles with MEM_TIMEOUT=255.
        hz.dmem_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("to_early", 32'(hz.mem_timeout), 32'd0);
        for (int i = 10; i < 256; i++) tick();
        check("to_set", 32'(hz.mem_timeout), 32'd1);
        clear_inputs(); tick(); tick();
        check("to_sticky", 32'(hz.mem_timeout), 32'd1);
        check("to_sc", 32'(hz.stall_count), 32'd270);

        // Reset mid-MULTI abandons the op.
        hz.EX_multi = 1'b1; tick(); tick();
        rst = 1'b1; settle();
        check("rstm_ctl", 32'(ctl()), 32'(C_NONE));
        tick();
        rst = 1'b0; hz.EX_multi = 1'b0; settle();
        check("rstm_run", 32'(ctl()), 32'(C_NONE));
        check("rstm_to", 32'(hz.mem_timeout), 32'd0);
        check("rstm_sc", 32'(hz.stall_count), 32'd0);
        hz.EX_multi = 1'b1; settle();
        check("rstm_new", 32'(ctl()), 32'(C_MULTI));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
